// File: rtl/chunked_adder_ctrl_pkg.sv
// chunked_adder_ctrl_pkg: shared state encoding and chunking helpers for multi-cycle arithmetic controllers
package chunked_adder_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int chunks(int w, int c);
        return w / c;
    endfunction
    function automatic bit width_ok(int w, int c);
        return c > 0 && w >= c && w % c == 0;
    endfunction
    function automatic int cnt_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/chunked_adder_ctrl_full_adder.sv
// full_adder: parameterised WIDTH-bit adder slice
// Ports: A, B (WIDTH) operands; Cin carry in; S (WIDTH) sum; Cout carry out of MSB.
module full_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    assign {Cout, S} = (WIDTH+1)'(A) + (WIDTH+1)'(B) + (WIDTH+1)'(Cin);
endmodule

// File: rtl/chunked_adder_ctrl.sv
// chunked_adder_ctrl: WIDTH-bit add done COUNT bits per cycle through one shared full_adder slice
// Ports: clk, rst (async, active-high); start/ready/busy/done handshake; A, B, Cin operands
// captured on the accepting edge; S, Cout registered result held until the next completion.
// Optional macro ADDSUB_SUB_EN adds input sub: when 1, computes A-B (Cout=1 means no borrow).
module chunked_adder_ctrl
    import chunked_adder_ctrl_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef ADDSUB_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int CHUNKS = chunks(WIDTH, COUNT);
    localparam int CW     = cnt_w(CHUNKS);

    if (!width_ok(WIDTH, COUNT)) begin : g_width_check
        $error("chunked_adder_ctrl: WIDTH must be a positive multiple of COUNT");
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_opa, r_opb, r_partial, r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout;
    logic [COUNT-1:0] w_slice_s;
    logic             w_slice_c, w_last;
    logic [WIDTH-1:0] w_partial, w_b_in;
    logic             w_c_in;

`ifdef ADDSUB_SUB_EN
    // Subtraction as A + ~B + 1.
    assign w_b_in = sub ? ~B : B;
    assign w_c_in = sub ? 1'b1 : Cin;
`else
    assign w_b_in = B;
    assign w_c_in = Cin;
`endif

    full_adder #(.WIDTH(COUNT)) u_slice (
        .A    (r_opa[COUNT-1:0]),
        .B    (r_opb[COUNT-1:0]),
        .Cin  (r_carry),
        .S    (w_slice_s),
        .Cout (w_slice_c)
    );

    // Slice result enters at the MSB end; after CHUNKS shifts chunk 0 sits at the LSB.
    // Written as a wide shift so WIDTH==COUNT needs no special case.
    assign w_partial = WIDTH'({w_slice_s, r_partial} >> COUNT);
    assign w_last    = r_cnt == CW'(CHUNKS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (start ? RUN : IDLE) :
                 r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
        ready  = r_state == IDLE;
        busy   = r_state == RUN;
        done   = r_state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_partial <= '0;
            r_s       <= '0;
            r_cout    <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_opa     <= A;
            r_opb     <= w_b_in;
            r_carry   <= w_c_in;
            r_cnt     <= '0;
            r_partial <= '0;
        end else if (r_state == RUN) begin
            r_partial <= w_partial;
            r_opa     <= r_opa >> COUNT;
            r_opb     <= r_opb >> COUNT;
            r_carry   <= w_slice_c;
            r_cnt     <= r_cnt + CW'(1);
            if (w_last) begin
                r_s    <= w_partial;
                r_cout <= w_slice_c;
            end
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
endmodule

// File: doc/chunked_adder_ctrl.md
Name: chunked_adder_ctrl

Overview:
Sequencer that performs a WIDTH-bit addition by driving one shared COUNT-bit full_adder slice over WIDTH/COUNT consecutive cycles. The carry is chained through a register between cycles. It is a controller in front of the existing parameterised ripple adder, trading latency for area when wide sums are needed. It uses a start/busy/done handshake so an upstream FSM can issue one operation at a time.

Parameters:
COUNT, 4, width of the full_adder slice instantiated inside (bits per cycle)
WIDTH, 16, operand/result width; must be an integer multiple of COUNT (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only when ready=1
A  input  WIDTH  operand A, captured on the accepting edge
B  input  WIDTH  operand B, captured on the accepting edge
Cin  input  1  carry in, captured on the accepting edge
ready  output  1  high only in IDLE; start is accepted only then
busy  output  1  high in RUN
done  output  1  one-cycle pulse: S/Cout are valid
S  output  WIDTH  registered sum; held until the next completion
Cout  output  1  registered carry out of the MSB slice; held like S

Behaviour:
- CHUNKS = WIDTH/COUNT. States are IDLE, RUN and DONE.
- Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, S=0, Cout=0. Operand, carry and counter registers are cleared. An operation in flight is aborted with no done pulse.
- IDLE: on an edge with start=1:
  - opA<=A, opB<=B, carry<=Cin, cnt<=0, partial<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: the slice is driven with opA[COUNT-1:0], opB[COUNT-1:0] and carry. On each edge:
  - partial<={slice S, partial[WIDTH-1:COUNT]} (the slice result shifts in from the MSB end).
  - opA and opB shift right by COUNT.
  - carry<=slice Cout; cnt<=cnt+1.
  - When cnt==CHUNKS-1: S<=final partial (including this slice), Cout<=slice Cout, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, ready=0; the next edge returns to IDLE.
- Latency: with the accepting edge as edge 0, done is high after edge CHUNKS. Throughput is one operation per CHUNKS+2 cycles.
- S and Cout never show partial values. They change only on entry to DONE or on reset.
- start while RUN or DONE is ignored; it is not queued. A start held high continuously is accepted on the first IDLE edge.
- CHUNKS==1 is legal: a single RUN cycle.
- All arithmetic is modulo 2^WIDTH; Cout carries the overflow.

Optional Feature:
ADDSUB_SUB_EN:
- Defined: adds input port sub (1 bit), captured with the operands. With sub=1, opB<=~B and carry<=1 (Cin ignored), giving S=A-B mod 2^WIDTH and Cout=1 when there is no borrow (A>=B unsigned). With sub=0, behaviour is identical to an add.
- Undefined: the sub port is absent and the block is add-only.

Decomposition:
- Shared package/header: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the CHUNKS derivation plus width check, reused by sibling multi-cycle arithmetic controllers.
- The only sub-module is the existing full_adder #(COUNT) slice, instantiated once. The FSM, shift registers and counter stay flat in this module.

Test Plan (WIDTH=16, COUNT=4):
- Reset pulse mid-cycle, then idle -> S=0x0000, Cout=0, busy=0, done=0, ready=1, all immediately on rst assertion.
- A=0x00FF, B=0x0001, Cin=0, start one cycle -> busy for 4 cycles, done pulse after edge 4, S=0x0100, Cout=0; carry propagates across chunk boundaries.
- A=0xFFFF, B=0x0001, Cin=1 -> S=0x0001, Cout=1; done pulse is exactly one cycle wide, and S/Cout stay held for 5 further idle cycles.
- Start A=0x1234, B=0x1111; hold start high with A=0xAAAA, B=0x5555 during RUN/DONE -> first result S=0x2345. The second operation is accepted on the first IDLE edge, giving S=0xFFFF, Cout=0.
- Assert rst after 2 RUN edges -> no done pulse, outputs reset. A following A=0x0F0F, B=0x0101, Cin=0 gives S=0x1010, Cout=0.
- With ADDSUB_SUB_EN and sub=1: A=0x0005, B=0x0007 -> S=0xFFFE, Cout=0; A=0x0007, B=0x0005 -> S=0x0002, Cout=1.
